// File: rtl/systolic_feeder_if.sv
// Operand stream into systolic_feeder: one k-slice (A column, B row) per beat.
// A beat transfers on a rising edge where s_valid && s_ready; payload is only meaningful while s_valid=1.
interface systolic_feeder_if #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4
);
    logic                        s_valid;
    logic                        s_ready;
    logic                        s_last;
    logic [ARR_HEIGHT*WIDTH-1:0] s_a;
    logic [ARR_WIDTH*WIDTH-1:0]  s_b;
    logic [1:0]                  s_simd;

    modport master (
        output s_valid, s_last, s_a, s_b, s_simd,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_last, s_a, s_b, s_simd,
        output s_ready
    );
endinterface

// File: rtl/systolic_feeder.sv
// Skews A/B k-slices onto the systolic array edges, flushes with zeros, then pulses done.
// Optional feature macro: SYSTOLIC_FEEDER_BEAT_CNT_EN adds the pass_beats counter output.
module systolic_feeder #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    systolic_feeder_if.slave            s,
    output logic [ARR_HEIGHT*WIDTH-1:0] in_a,
    output logic [ARR_WIDTH*WIDTH-1:0]  in_b,
    output logic [1:0]                  SIMD_control,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  state_dbg
`ifdef SYSTOLIC_FEEDER_BEAT_CNT_EN
    ,
    output logic [15:0]                 pass_beats
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int              CNT_W      = $clog2(ARR_HEIGHT + ARR_WIDTH);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(ARR_HEIGHT + ARR_WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [1:0]       simd_q, simd_d;
    logic             accept;

    assign s.s_ready    = (state_q != ST_FLUSH);
    assign accept       = s.s_valid && s.s_ready;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign SIMD_control = simd_q;
    assign state_dbg    = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        simd_d  = simd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    simd_d = s.s_simd;
                    if (s.s_last) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                if (accept && s.s_last) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            simd_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            simd_q  <= simd_d;
        end
    end

    // Row i is an (i+1)-deep shift chain; head in the low slot, tail drives the array edge.
    for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_row
        logic [(i+1)*WIDTH-1:0] chain_q, chain_d;

        always_comb begin
            chain_d              = chain_q << WIDTH;
            chain_d[WIDTH-1:0]   = accept ? s.s_a[i*WIDTH +: WIDTH] : '0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) chain_q <= '0;
            else        chain_q <= chain_d;
        end

        assign in_a[i*WIDTH +: WIDTH] = chain_q[i*WIDTH +: WIDTH];
    end

    for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_col
        logic [(j+1)*WIDTH-1:0] chain_q, chain_d;

        always_comb begin
            chain_d              = chain_q << WIDTH;
            chain_d[WIDTH-1:0]   = accept ? s.s_b[j*WIDTH +: WIDTH] : '0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) chain_q <= '0;
            else        chain_q <= chain_d;
        end

        assign in_b[j*WIDTH +: WIDTH] = chain_q[j*WIDTH +: WIDTH];
    end

`ifdef SYSTOLIC_FEEDER_BEAT_CNT_EN
    logic [15:0] beats_q, beats_d;

    always_comb begin
        beats_d = beats_q;
        if (accept) begin
            if (state_q == ST_IDLE)      beats_d = 16'd1;
            else if (beats_q != 16'hFFFF) beats_d = beats_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) beats_q <= '0;
        else        beats_q <= beats_d;
    end

    assign pass_beats = beats_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: vector table, hand-written corner sequences and a random run
// checked against a timestamp-based model of the skew, flush and handshake rules.
module tb_systolic_feeder;
    localparam int W    = 16;
    localparam int H    = 4;
    localparam int WA   = 4;
    localparam int AW   = H * W;
    localparam int BW   = WA * W;
    localparam int HIST = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic [1:0]    simd_ctl;
    logic [1:0]    state_dbg;
    logic          busy;
    logic          done;
`ifdef SYSTOLIC_FEEDER_BEAT_CNT_EN
    logic [15:0]   pass_beats;
`endif

    systolic_feeder_if #(.WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(WA)) bus ();

    systolic_feeder #(.WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(WA)) dut (
        .clk          (clk),
        .reset        (reset),
        .s            (bus.slave),
        .in_a         (in_a),
        .in_b         (in_b),
        .SIMD_control (simd_ctl),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
`ifdef SYSTOLIC_FEEDER_BEAT_CNT_EN
        ,
        .pass_beats   (pass_beats)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    // Reference model: which slice was accepted at which edge, plus pass bookkeeping.
    int            ecount;
    bit            hv [HIST];
    logic [AW-1:0] ha [HIST];
    logic [BW-1:0] hb [HIST];
    logic [AW-1:0] rec_a [HIST];
    logic [BW-1:0] rec_b [HIST];
    bit            m_ready, m_in_pass, m_flushing, m_done;
    int            m_flush_end;
    logic [1:0]    m_simd;
    int            m_beats;

    typedef struct packed {
        logic        v;
        logic        l;
        logic [7:0]  k;
        logic        busy;
        logic        ready;
        logic        done;
        logic [15:0] row2;
        logic [15:0] col3;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    function automatic logic [AW-1:0] mk_a(input int k);
        logic [AW-1:0] r;
        for (int i = 0; i < H; i++) r[i*W +: W] = W'((i + 1) * k);
        return r;
    endfunction

    function automatic logic [BW-1:0] mk_b(input int k);
        logic [BW-1:0] r;
        for (int j = 0; j < WA; j++) r[j*W +: W] = W'((10 + j) * k);
        return r;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < HIST; n++) hv[n] = 1'b0;
        m_ready = 1'b1; m_in_pass = 1'b0; m_flushing = 1'b0; m_done = 1'b0;
        m_simd = 2'b00; m_beats = 0; m_flush_end = 0;
    endtask

    task automatic model_edge(input logic v, input logic l, input logic [AW-1:0] a,
                              input logic [BW-1:0] b, input logic [1:0] sm);
        bit acc;
        acc = v && m_ready;
        ecount++;
        hv[ecount] = acc;
        ha[ecount] = a;
        hb[ecount] = b;
        m_done = 1'b0;
        if (acc) begin
            if (!m_in_pass) begin
                m_in_pass = 1'b1;
                m_simd    = sm;
                m_beats   = 1;
            end else if (m_beats < 65535) begin
                m_beats++;
            end
            if (l) begin
                m_flushing  = 1'b1;
                m_flush_end = ecount + H + WA;
            end
        end else if (m_flushing && ecount == m_flush_end) begin
            m_done     = 1'b1;
            m_flushing = 1'b0;
            m_in_pass  = 1'b0;
        end
        m_ready = !m_flushing;
    endtask

    task automatic check_outputs();
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        ea = '0;
        eb = '0;
        for (int i = 0; i < H; i++)
            if (hv[ecount - i]) ea[i*W +: W] = ha[ecount - i][i*W +: W];
        for (int j = 0; j < WA; j++)
            if (hv[ecount - j]) eb[j*W +: W] = hb[ecount - j][j*W +: W];
        check("in_a", in_a, ea);
        check("in_b", in_b, eb);
        check("simd", simd_ctl, m_simd);
        check("busy", busy, m_in_pass);
        check("done", done, m_done);
        check("s_ready", bus.s_ready, m_ready);
`ifdef SYSTOLIC_FEEDER_BEAT_CNT_EN
        check("pass_beats", pass_beats, m_beats);
`endif
        rec_a[ecount] = in_a;
        rec_b[ecount] = in_b;
    endtask

    // Called just after a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic cycle(input logic v, input logic l, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [1:0] sm);
        bus.s_valid = v;
        bus.s_last  = l;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_simd  = sm;
        @(posedge clk);
        model_edge(v, l, a, b, sm);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, '0, '0, 2'b00);
    endtask

    task automatic wait_done(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (done) return;
            idle(1);
        end
        check("done_timeout", done, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 16'd3,  16'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 16'd6,  16'd13};
        tbl[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd9,  16'd26};
        tbl[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd12, 16'd39};
        tbl[6]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd52};
        tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0};
        tbl[8]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0};
        tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0};
        tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 16'd0,  16'd0};
        tbl[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd0,  16'd0};

        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_simd = 2'b00;
        ecount = 16;
        model_reset();

        // Clock/reset: hold reset, check cleared outputs, release away from the rising edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_a", in_a, '0);
        check("rst_in_b", in_b, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_simd", simd_ctl, 2'b00);
        reset = 1'b1;
        #1;
        check("rst_ready", bus.s_ready, 1'b1);
        idle(4);

        // Vector table: 4-beat gap-free pass, A=(i+1)*k, B=(10+j)*k.
        for (int e = 0; e < 13; e++) begin
            cycle(tbl[e].v, tbl[e].l, mk_a(int'(tbl[e].k)), mk_b(int'(tbl[e].k)), 2'b00);
            check("tbl_busy",  busy,            tbl[e].busy);
            check("tbl_ready", bus.s_ready,     tbl[e].ready);
            check("tbl_done",  done,            tbl[e].done);
            check("tbl_row2",  in_a[2*W +: W],  tbl[e].row2);
            check("tbl_col3",  in_b[3*W +: W],  tbl[e].col3);
        end
        idle(3);

        // Same pass with a 2-cycle gap; a modelled output-stationary array must reach A*B.
        begin
            int start;
            start = ecount + 1;
            cycle(1'b1, 1'b0, mk_a(1), mk_b(1), 2'b00);
            cycle(1'b1, 1'b0, mk_a(2), mk_b(2), 2'b00);
            idle(2);
            cycle(1'b1, 1'b0, mk_a(3), mk_b(3), 2'b00);
            cycle(1'b1, 1'b1, mk_a(4), mk_b(4), 2'b00);
            wait_done(20);
            for (int i = 0; i < H; i++) begin
                for (int j = 0; j < WA; j++) begin
                    int acc;
                    acc = 0;
                    for (int t = start; t <= ecount; t++)
                        if (t - j >= start && t - i >= start)
                            acc += int'(rec_a[t-j][i*W +: W]) * int'(rec_b[t-i][j*W +: W]);
                    check("gap_out_c", acc, (i + 1) * (10 + j) * 30);
                end
            end
        end
        idle(2);

        // Reset mid-FEED, two beats in; a following single-beat pass must complete.
        cycle(1'b1, 1'b0, mk_a(5), mk_b(5), 2'b11);
        cycle(1'b1, 1'b0, mk_a(6), mk_b(6), 2'b11);
        #2 reset = 1'b0;
        #1;
        check("midrst_in_a", in_a, '0);
        check("midrst_in_b", in_b, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        cycle(1'b1, 1'b1, mk_a(7), mk_b(7), 2'b01);
        wait_done(20);
        check("midrst_pass_done", done, 1'b1);
        idle(2);

        // Single beat with s_last and simd=10; ready low for H+W cycles, then new beat in done cycle.
        begin
            int low;
            int n;
            low = 0;
            n   = 0;
            cycle(1'b1, 1'b1, mk_a(9), mk_b(9), 2'b10);
            while (!done && n < 20) begin
                if (!bus.s_ready) low++;
                check("single_simd", simd_ctl, 2'b10);
                idle(1);
                n++;
            end
            check("single_done", done, 1'b1);
            check("single_ready_low", low, H + WA);
            check("single_simd_at_done", simd_ctl, 2'b10);
            cycle(1'b1, 1'b0, mk_a(2), mk_b(2), 2'b01);
            check("donecyc_simd", simd_ctl, 2'b01);
            check("donecyc_busy", busy, 1'b1);
            cycle(1'b1, 1'b1, mk_a(3), mk_b(3), 2'b00);
            wait_done(20);
            check("donecyc_simd_hold", simd_ctl, 2'b01);
        end
        idle(2);

`ifdef SYSTOLIC_FEEDER_BEAT_CNT_EN
        // Five beats with gaps, then the next pass restarts the count.
        cycle(1'b1, 1'b0, mk_a(1), mk_b(1), 2'b00);
        idle(1);
        cycle(1'b1, 1'b0, mk_a(2), mk_b(2), 2'b00);
        cycle(1'b1, 1'b0, mk_a(3), mk_b(3), 2'b00);
        idle(1);
        cycle(1'b1, 1'b0, mk_a(4), mk_b(4), 2'b00);
        cycle(1'b1, 1'b1, mk_a(5), mk_b(5), 2'b00);
        wait_done(20);
        check("beats_at_done", pass_beats, 16'd5);
        cycle(1'b1, 1'b0, mk_a(1), mk_b(1), 2'b00);
        check("beats_restart", pass_beats, 16'd1);
        cycle(1'b1, 1'b1, mk_a(1), mk_b(1), 2'b00);
        wait_done(20);
        idle(2);
`endif

        // Random traffic, including beats offered while flushing.
        for (int c = 0; c < 400; c++) begin
            logic [AW-1:0] ra;
            logic [BW-1:0] rb;
            for (int i = 0; i < H; i++)  ra[i*W +: W] = W'($urandom);
            for (int j = 0; j < WA; j++) rb[j*W +: W] = W'($urandom);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, ra, rb,
                  2'($urandom_range(0, 3)));
        end
        if (busy) wait_done(40);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
